// File: rtl/wb_periph_decoder_pkg.sv
// -----------------------------------------------------------------------------
// wb_periph_decoder_pkg
// Shared definitions for the peripheral Wishbone decoder: decoder state
// encoding, error codes reported on err_code_o, and the peripheral decode
// constants that the bridge's address translation also uses.
// -----------------------------------------------------------------------------
package wb_periph_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_DONE     = 2'd2,
      ST_DONE_ERR = 2'd3
   } dec_state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_UNMAPPED = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   // Decode field position inside the translated peripheral address
   localparam int DEC_LSB = 13;
   localparam int DEC_W   = 7;

   localparam logic [DEC_W-1:0] D_P_MATRIX_SEL = 7'h23;  // pin-mux, block 2 / sub 3
   localparam logic [DEC_W-1:0] DRIVE_I2CT_SEL = 7'h43;  // I2C target, block 4 / sub 3

endpackage

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Saturating cycle counter used to bound how long a Wishbone slave may stall.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   start    : clears the count to 0 (takes priority over en)
//   en       : count this cycle
//   expired  : en is high and the count has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module wb_timeout_cnt #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (en && (cnt != SAT)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/wb_periph_decoder.sv
// -----------------------------------------------------------------------------
// wb_periph_decoder
// Single-master Wishbone address decoder / response mux for the peripheral
// slaves. Routes one cycle at a time to the slave whose decode value matches
// addr[19:13], returns its data and ack, and terminates unmapped or stalled
// accesses with an error ack so the upstream bridge never deadlocks.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   m_*                  : master-side Wishbone (ack/rdata registered)
//   s_addr/wdata/we/sel  : registered broadcast to all slaves
//   s_cyc_o, s_stb_o     : one-hot per-slave cycle/strobe
//   s_rdata_i, s_ack_i   : packed per-slave read data, per-slave ack
//   err_o, err_code_o    : sticky error flag and last error code
//   err_clr_i            : synchronous clear of the error flag/code
// -----------------------------------------------------------------------------
module wb_periph_decoder
   import wb_periph_decoder_pkg::*;
#(
   parameter int                         ADDR_W      = 32,
   parameter int                         DATA_W      = 32,
   parameter int                         N_SLV       = 2,
   parameter logic [N_SLV*DEC_W-1:0]     SLV_SEL     = {DRIVE_I2CT_SEL, D_P_MATRIX_SEL},
   parameter int                         TIMEOUT_CYC = 255,
   parameter logic [DATA_W-1:0]          ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_W-1:0]       m_addr_i,
   input  logic [DATA_W-1:0]       m_wdata_i,
   input  logic                    m_we_i,
   input  logic [DATA_W/8-1:0]     m_sel_i,
   input  logic                    m_stb_i,
   input  logic                    m_cyc_i,
   output logic [DATA_W-1:0]       m_rdata_o,
   output logic                    m_ack_o,
   output logic [ADDR_W-1:0]       s_addr_o,
   output logic [DATA_W-1:0]       s_wdata_o,
   output logic                    s_we_o,
   output logic [DATA_W/8-1:0]     s_sel_o,
   output logic [N_SLV-1:0]        s_cyc_o,
   output logic [N_SLV-1:0]        s_stb_o,
   input  logic [N_SLV*DATA_W-1:0] s_rdata_i,
   input  logic [N_SLV-1:0]        s_ack_i,
   output logic                    err_o,
   output logic [1:0]              err_code_o,
   input  logic                    err_clr_i
);

   localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

   dec_state_e         state, next_state;
   logic [IDX_W-1:0]   sel_idx, dec_idx;
   logic               dec_hit;
   logic               accept;
   logic               tmo_start, tmo_exp;
   logic               sel_ack;
   logic [DATA_W-1:0]  sel_rdata;
   logic               err_set;
   logic [1:0]         err_code_nxt;

   assign accept    = m_cyc_i & m_stb_i;
   assign sel_ack   = s_ack_i[sel_idx];
   assign sel_rdata = s_rdata_i[sel_idx*DATA_W +: DATA_W];

   // Descending scan so the lowest matching index is the one left standing
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int k = N_SLV - 1; k >= 0; k--) begin
         if (m_addr_i[DEC_LSB +: DEC_W] == SLV_SEL[k*DEC_W +: DEC_W]) begin
            dec_hit = 1'b1;
            dec_idx = IDX_W'(k);
         end
      end
   end

   assign tmo_start = (state == ST_IDLE) && accept && dec_hit;

   wb_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start   (tmo_start),
      .en      (state == ST_ACTIVE),
      .expired (tmo_exp)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= next_state;
   end

   // Next-state logic. A master abort outranks the slave ack; the selected
   // slave's ack outranks a timeout landing on the same cycle.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) next_state = dec_hit ? ST_ACTIVE : ST_DONE_ERR;
         end
         ST_ACTIVE: begin
            if (!m_cyc_i)     next_state = ST_IDLE;
            else if (sel_ack) next_state = ST_DONE;
            else if (tmo_exp) next_state = ST_DONE_ERR;
         end
         ST_DONE:     next_state = ST_IDLE;
         ST_DONE_ERR: next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
   end

   // Output logic: only the latched slave sees cyc/stb, and only while ACTIVE
   always_comb begin
      s_cyc_o = '0;
      if (state == ST_ACTIVE) s_cyc_o[sel_idx] = 1'b1;
   end
   assign s_stb_o = s_cyc_o;

   assign err_set      = (next_state == ST_DONE_ERR);
   assign err_code_nxt = (state == ST_IDLE) ? ERR_UNMAPPED : ERR_TIMEOUT;

   // Registered master response, broadcast capture and error status
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_ack_o    <= 1'b0;
         m_rdata_o  <= '0;
         s_addr_o   <= '0;
         s_wdata_o  <= '0;
         s_we_o     <= 1'b0;
         s_sel_o    <= '0;
         sel_idx    <= '0;
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
      end else begin
         m_ack_o <= (next_state == ST_DONE) || (next_state == ST_DONE_ERR);

         if ((state == ST_IDLE) && accept) begin
            s_addr_o  <= m_addr_i;
            s_wdata_o <= m_wdata_i;
            s_we_o    <= m_we_i;
            s_sel_o   <= m_sel_i;
            sel_idx   <= dec_idx;
         end

         if ((state == ST_ACTIVE) && (next_state == ST_DONE)) begin
            m_rdata_o <= sel_rdata;
         end else if (next_state == ST_DONE_ERR) begin
            m_rdata_o <= ERR_DATA;
         end

         // A new error in the same cycle as a clear request keeps the flag set
         if (err_set) begin
            err_o      <= 1'b1;
            err_code_o <= err_code_nxt;
         end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
         end
      end
   end

endmodule

// File: tb/tb_wb_periph_decoder.sv
module tb_wb_periph_decoder;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int N_SLV  = 2;
   localparam int TMO    = 8;

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b0;
   logic [ADDR_W-1:0]       m_addr_i = '0;
   logic [DATA_W-1:0]       m_wdata_i = '0;
   logic                    m_we_i = 1'b0;
   logic [DATA_W/8-1:0]     m_sel_i = '0;
   logic                    m_stb_i = 1'b0;
   logic                    m_cyc_i = 1'b0;
   logic [DATA_W-1:0]       m_rdata_o;
   logic                    m_ack_o;
   logic [ADDR_W-1:0]       s_addr_o;
   logic [DATA_W-1:0]       s_wdata_o;
   logic                    s_we_o;
   logic [DATA_W/8-1:0]     s_sel_o;
   logic [N_SLV-1:0]        s_cyc_o;
   logic [N_SLV-1:0]        s_stb_o;
   logic [N_SLV*DATA_W-1:0] s_rdata_i = '0;
   logic [N_SLV-1:0]        s_ack_i = '0;
   logic                    err_o;
   logic [1:0]              err_code_o;
   logic                    err_clr_i = 1'b0;

   int n_chk = 0;
   int n_bad = 0;

   wb_periph_decoder #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .N_SLV       (N_SLV),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .m_addr_i   (m_addr_i),
      .m_wdata_i  (m_wdata_i),
      .m_we_i     (m_we_i),
      .m_sel_i    (m_sel_i),
      .m_stb_i    (m_stb_i),
      .m_cyc_i    (m_cyc_i),
      .m_rdata_o  (m_rdata_o),
      .m_ack_o    (m_ack_o),
      .s_addr_o   (s_addr_o),
      .s_wdata_o  (s_wdata_o),
      .s_we_o     (s_we_o),
      .s_sel_o    (s_sel_o),
      .s_cyc_o    (s_cyc_o),
      .s_stb_o    (s_stb_o),
      .s_rdata_i  (s_rdata_i),
      .s_ack_i    (s_ack_i),
      .err_o      (err_o),
      .err_code_o (err_code_o),
      .err_clr_i  (err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One master transaction. Called 1 time unit after a rising edge (cycle 0).
   // The addressed slave acks on its ack_at-th strobe cycle (0 = never);
   // with stray set, the other slave acks on every strobe cycle.
   task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] sel, input int slv, input int ack_at,
                       input logic [31:0] sdata, input logic stray,
                       output int n_stb, output logic [1:0] stb_or, output int ack_cyc,
                       output logic [31:0] rdata, output logic ack_after,
                       output logic [31:0] cap_wdata, output logic [3:0] cap_sel,
                       output logic cap_we, output logic [31:0] cap_addr);
      s_rdata_i = {32'h0BAD_0BAD, 32'h0BAD_0BAD};
      s_rdata_i[slv*32 +: 32] = sdata;
      m_addr_i  = addr;
      m_wdata_i = wdata;
      m_we_i    = we;
      m_sel_i   = sel;
      m_cyc_i   = 1'b1;
      m_stb_i   = 1'b1;
      n_stb = 0; stb_or = '0; ack_cyc = -1; rdata = '0;
      cap_wdata = '0; cap_sel = '0; cap_we = 1'b0; cap_addr = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk_i); #1;
         s_ack_i = '0;
         if (m_ack_o) begin
            ack_cyc = c;
            rdata   = m_rdata_o;
            m_cyc_i = 1'b0;
            m_stb_i = 1'b0;
            break;
         end
         if (s_stb_o != '0) begin
            n_stb++;
            stb_or |= s_stb_o;
            if (n_stb == 1) begin
               cap_wdata = s_wdata_o; cap_sel = s_sel_o;
               cap_we = s_we_o; cap_addr = s_addr_o;
            end
            if (n_stb == ack_at) s_ack_i[slv] = 1'b1;
            if (stray) s_ack_i[1-slv] = 1'b1;
         end
      end
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      @(posedge clk_i); #1;
      s_ack_i = '0;
      ack_after = m_ack_o;
   endtask

   task automatic clear_err();
      err_clr_i = 1'b1;
      @(posedge clk_i); #1;
      err_clr_i = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n_stb, ack_cyc;
      logic [1:0] stb_or;
      logic [31:0] rdata, cw, ca;
      logic [3:0] cs;
      logic cwe, aa, seen;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ack",   m_ack_o,    1'b0);
      check("rst_rdata", m_rdata_o,  32'h0);
      check("rst_stb",   s_stb_o,    2'b00);
      check("rst_cyc",   s_cyc_o,    2'b00);
      check("rst_err",   err_o,      1'b0);
      check("rst_code",  err_code_o, 2'b00);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Read slave 0, acks on 3rd strobe cycle
      xfer(32'h0004_6000, 32'h0, 1'b0, 4'hF, 0, 3, 32'h1234_5678, 1'b0,
           n_stb, stb_or, ack_cyc, rdata, aa, cw, cs, cwe, ca);
      check("rd0_nstb",  n_stb,   3);
      check("rd0_stbs",  stb_or,  2'b01);
      check("rd0_ackc",  ack_cyc, 4);
      check("rd0_data",  rdata,   32'h1234_5678);
      check("rd0_pulse", aa,      1'b0);
      check("rd0_addr",  ca,      32'h0004_6000);
      check("rd0_err",   err_o,   1'b0);

      // Write slave 1, zero-wait
      xfer(32'h0008_6000, 32'hA5A5_0001, 1'b1, 4'b0011, 1, 1, 32'h0, 1'b0,
           n_stb, stb_or, ack_cyc, rdata, aa, cw, cs, cwe, ca);
      check("wr1_nstb",  n_stb,   1);
      check("wr1_stbs",  stb_or,  2'b10);
      check("wr1_ackc",  ack_cyc, 2);
      check("wr1_wdata", cw,      32'hA5A5_0001);
      check("wr1_sel",   cs,      4'b0011);
      check("wr1_we",    cwe,     1'b1);
      check("wr1_pulse", aa,      1'b0);

      // Unmapped
      xfer(32'h0001_0000, 32'h0, 1'b0, 4'hF, 0, 1, 32'h0, 1'b0,
           n_stb, stb_or, ack_cyc, rdata, aa, cw, cs, cwe, ca);
      check("um_nstb",  n_stb,      0);
      check("um_ackc",  ack_cyc,    1);
      check("um_data",  rdata,      32'hDEAD_BEEF);
      check("um_err",   err_o,      1'b1);
      check("um_code",  err_code_o, 2'b01);
      check("um_pulse", aa,         1'b0);
      clear_err();
      check("um_clr_err",  err_o,      1'b0);
      check("um_clr_code", err_code_o, 2'b00);

      // Timeout on slave 1
      xfer(32'h0008_6004, 32'h0, 1'b0, 4'hF, 1, 0, 32'h0, 1'b0,
           n_stb, stb_or, ack_cyc, rdata, aa, cw, cs, cwe, ca);
      check("to_nstb", n_stb,      TMO);
      check("to_stbs", stb_or,     2'b10);
      check("to_ackc", ack_cyc,    TMO + 1);
      check("to_data", rdata,      32'hDEAD_BEEF);
      check("to_err",  err_o,      1'b1);
      check("to_code", err_code_o, 2'b10);
      clear_err();
      check("to_clr_err",  err_o,      1'b0);
      check("to_clr_code", err_code_o, 2'b00);

      // Ack on the timeout cycle, stray acks from slave 1 throughout
      xfer(32'h0004_6008, 32'h0, 1'b0, 4'hF, 0, TMO, 32'hCAFE_0005, 1'b1,
           n_stb, stb_or, ack_cyc, rdata, aa, cw, cs, cwe, ca);
      check("edge_nstb", n_stb,      TMO);
      check("edge_stbs", stb_or,     2'b01);
      check("edge_ackc", ack_cyc,    TMO + 1);
      check("edge_data", rdata,      32'hCAFE_0005);
      check("edge_err",  err_o,      1'b0);
      check("edge_code", err_code_o, 2'b00);

      // Master drops cyc mid-transaction: no ack, no error
      m_addr_i = 32'h0008_6000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
      @(posedge clk_i); #1;
      check("ab_stb", s_stb_o, 2'b10);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         seen |= m_ack_o;
      end
      check("ab_stb_off", s_stb_o, 2'b00);
      check("ab_no_ack",  seen,    1'b0);
      check("ab_err",     err_o,   1'b0);

      // Reset while slave 0 is strobed
      m_addr_i = 32'h0004_6000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("mr_pre_stb", s_stb_o, 2'b01);
      rst_ni = 1'b0;
      #1;
      check("mr_stb",   s_stb_o,   2'b00);
      check("mr_cyc",   s_cyc_o,   2'b00);
      check("mr_ack",   m_ack_o,   1'b0);
      check("mr_rdata", m_rdata_o, 32'h0);
      check("mr_addr",  s_addr_o,  32'h0);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         seen |= m_ack_o;
      end
      check("mr_no_ack", seen, 1'b0);
      xfer(32'h0004_6000, 32'h0, 1'b0, 4'hF, 0, 2, 32'h0F0F_3C3C, 1'b0,
           n_stb, stb_or, ack_cyc, rdata, aa, cw, cs, cwe, ca);
      check("mr_post_ackc", ack_cyc, 3);
      check("mr_post_data", rdata,   32'h0F0F_3C3C);
      check("mr_post_stbs", stb_or,  2'b01);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
